// File: rtl/riscv_io_uart.sv
// riscv_io_uart: memory-mapped 8N1 UART with a small TX FIFO,
// single-byte RX holding register and programmable baud divisor.
module riscv_io_uart #(
  parameter string                        PLATFORM           = "XILINX",
  parameter int                           BUS_ADDR_DATA_LEN  = 13,
  parameter logic [BUS_ADDR_DATA_LEN-1:0] DATA_ADDR          = 'h00,
  parameter logic [BUS_ADDR_DATA_LEN-1:0] STATUS_ADDR        = 'h04,
  parameter logic [BUS_ADDR_DATA_LEN-1:0] BAUD_ADDR          = 'h08,
  parameter int                           TX_FIFO_DEPTH_LOG2 = 2,
  parameter logic [15:0]                  BAUD_DIV_RESET     = 16'd867
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [BUS_ADDR_DATA_LEN-1:0] addr_i,
  input  logic                         wr_i,
  input  logic                         rd_i,
  input  logic [31:0]                  bus_i,
  output logic [31:0]                  bus_o,
  input  logic                         rx_i,
  output logic                         tx_o,
  output logic                         irq_o
);

  localparam int  PW        = TX_FIFO_DEPTH_LOG2;
  localparam int  DEPTH     = 1 << PW;
  localparam bit  IS_XILINX = (PLATFORM == "XILINX");

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  logic [15:0] baud_div;
  logic        rx_valid, rx_overrun, rx_ferr, tx_drop;
  logic [7:0]  rx_data;

  logic sel_data, sel_stat, sel_baud;
  logic wr_data, wr_stat, push, drop_set;

  assign sel_data = (addr_i == DATA_ADDR);
  assign sel_stat = (addr_i == STATUS_ADDR);
  assign sel_baud = (addr_i == BAUD_ADDR);
  assign wr_data  = wr_i & sel_data;
  assign wr_stat  = wr_i & sel_stat;

  // TX FIFO: pointers carry one extra wrap bit
  logic [7:0]  fifo_mem [DEPTH];
  logic [PW:0] wr_ptr, rd_ptr;
  logic        tx_full, tx_empty, tx_pop;
  logic [7:0]  fifo_head;

  assign tx_empty  = (wr_ptr == rd_ptr);
  assign tx_full   = ((wr_ptr - rd_ptr) == (PW+1)'(DEPTH));
  assign push      = wr_data & ~tx_full;
  assign drop_set  = wr_data & tx_full;
  assign fifo_head = fifo_mem[rd_ptr[PW-1:0]];

  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wr_ptr[PW-1:0]] <= bus_i[7:0];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (tx_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // TX FSM
  state_t      tx_state, tx_state_n;
  logic [15:0] tx_cnt, tx_cnt_n, tx_div, tx_div_n;
  logic [2:0]  tx_bit, tx_bit_n;
  logic [7:0]  tx_shift, tx_shift_n;
  logic        tx_n, tx_tick, tx_busy;

  assign tx_tick = (tx_cnt == tx_div);
  assign tx_busy = (tx_state != S_IDLE);

  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt + 16'd1;
    tx_div_n   = tx_div;
    tx_bit_n   = tx_bit;
    tx_shift_n = tx_shift;
    tx_pop     = 1'b0;
    tx_n       = 1'b1;
    unique case (tx_state)
      S_IDLE: begin
        tx_cnt_n = '0;
        if (!tx_empty) begin
          tx_pop     = 1'b1;
          tx_state_n = S_START;
        end
      end
      S_START: begin
        if (tx_tick) begin
          tx_cnt_n   = '0;
          tx_bit_n   = '0;
          tx_state_n = S_DATA;
        end
      end
      S_DATA: begin
        if (tx_tick) begin
          tx_cnt_n   = '0;
          tx_shift_n = tx_shift >> 1;
          tx_bit_n   = tx_bit + 3'd1;
          if (tx_bit == 3'd7) tx_state_n = S_STOP;
        end
      end
      S_STOP: begin
        if (tx_tick) begin
          tx_cnt_n = '0;
          if (!tx_empty) begin
            tx_pop     = 1'b1;
            tx_state_n = S_START;
          end else begin
            tx_state_n = S_IDLE;
          end
        end
      end
      default: tx_state_n = S_IDLE;
    endcase
    if (tx_pop) begin
      tx_shift_n = fifo_head;
      tx_div_n   = baud_div;
    end
    unique case (tx_state_n)
      S_START: tx_n = 1'b0;
      S_DATA:  tx_n = tx_shift_n[0];
      default: tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tx_state <= S_IDLE;
      tx_cnt   <= '0;
      tx_div   <= BAUD_DIV_RESET;
      tx_bit   <= '0;
      tx_shift <= '0;
      tx_o     <= 1'b1;
    end else begin
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_div   <= tx_div_n;
      tx_bit   <= tx_bit_n;
      tx_shift <= tx_shift_n;
      tx_o     <= tx_n;
    end
  end

  // RX: 2-flop synchronizer plus one history flop for edge detect
  logic        rx_s1, rx_s2, rx_s3, rx_fall;
  state_t      rx_state, rx_state_n;
  logic [15:0] rx_cnt, rx_cnt_n, rx_div, rx_div_n;
  logic [15:0] rx_half, rx_half_n, rx_lim;
  logic [2:0]  rx_bit, rx_bit_n;
  logic [7:0]  rx_shift, rx_shift_n;
  logic        rx_done, ferr_set, rx_tick;
  logic [16:0] baud_p1;

  assign rx_fall = rx_s3 & ~rx_s2;
  assign baud_p1 = {1'b0, baud_div} + 17'd1;
  assign rx_lim  = (rx_state == S_START) ? rx_half : rx_div;
  assign rx_tick = (rx_cnt == rx_lim);

  always_comb begin
    rx_state_n = rx_state;
    rx_cnt_n   = rx_cnt + 16'd1;
    rx_div_n   = rx_div;
    rx_half_n  = rx_half;
    rx_bit_n   = rx_bit;
    rx_shift_n = rx_shift;
    rx_done    = 1'b0;
    ferr_set   = 1'b0;
    unique case (rx_state)
      S_IDLE: begin
        rx_cnt_n = '0;
        if (rx_fall) begin
          rx_state_n = S_START;
          rx_div_n   = baud_div;
          rx_half_n  = 16'((baud_p1 >> 1) - 17'd1);
        end
      end
      S_START: begin
        if (rx_tick) begin
          rx_cnt_n   = '0;
          rx_bit_n   = '0;
          rx_state_n = rx_s2 ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (rx_tick) begin
          rx_cnt_n   = '0;
          rx_shift_n = {rx_s2, rx_shift[7:1]};
          rx_bit_n   = rx_bit + 3'd1;
          if (rx_bit == 3'd7) rx_state_n = S_STOP;
        end
      end
      S_STOP: begin
        if (rx_tick) begin
          rx_state_n = S_IDLE;
          rx_done    = rx_s2;
          ferr_set   = ~rx_s2;
        end
      end
      default: rx_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_s3    <= 1'b1;
      rx_state <= S_IDLE;
      rx_cnt   <= '0;
      rx_div   <= BAUD_DIV_RESET;
      rx_half  <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      rx_s1    <= rx_i;
      rx_s2    <= rx_s1;
      rx_s3    <= rx_s2;
      rx_state <= rx_state_n;
      rx_cnt   <= rx_cnt_n;
      rx_div   <= rx_div_n;
      rx_half  <= rx_half_n;
      rx_bit   <= rx_bit_n;
      rx_shift <= rx_shift_n;
    end
  end

  // Status/config registers; a set event always beats a same-cycle clear
  logic clr_valid, clr_ovr, clr_ferr, clr_drop;

  assign clr_valid = wr_stat & bus_i[2];
  assign clr_ovr   = wr_stat & bus_i[3];
  assign clr_ferr  = wr_stat & bus_i[5];
  assign clr_drop  = wr_stat & bus_i[6];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      baud_div   <= BAUD_DIV_RESET;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      rx_overrun <= 1'b0;
      rx_ferr    <= 1'b0;
      tx_drop    <= 1'b0;
    end else begin
      if (wr_i && sel_baud) baud_div <= bus_i[15:0];
      if (rx_done) rx_data <= rx_shift;
      if (rx_done)        rx_valid <= 1'b1;
      else if (clr_valid) rx_valid <= 1'b0;
      if (rx_done && rx_valid && !clr_valid) rx_overrun <= 1'b1;
      else if (clr_ovr)                      rx_overrun <= 1'b0;
      if (ferr_set)      rx_ferr <= 1'b1;
      else if (clr_ferr) rx_ferr <= 1'b0;
      if (drop_set)      tx_drop <= 1'b1;
      else if (clr_drop) tx_drop <= 1'b0;
    end
  end

  logic [31:0] status, rd_data;

  assign status = {25'b0, tx_drop, rx_ferr, tx_busy,
                   rx_overrun, rx_valid, tx_empty, tx_full};

  always_comb begin
    rd_data = '0;
    if (rd_i) begin
      unique case (1'b1)
        sel_data: rd_data = {24'b0, rx_data};
        sel_stat: rd_data = status;
        sel_baud: rd_data = {16'b0, baud_div};
        default:  rd_data = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) bus_o <= '0;
    else       bus_o <= rd_data;
  end

  assign irq_o = rx_valid;

  logic unused_bits;
  assign unused_bits = ^{bus_i[31:16], IS_XILINX};

endmodule

// File: tb/tb_riscv_io_uart.sv
// tb_riscv_io_uart: randomized self-checking bench for riscv_io_uart
// with a frame-level serial model and a status scoreboard.
module tb_riscv_io_uart;

  localparam logic [12:0] A_DATA = 13'h000;
  localparam logic [12:0] A_STAT = 13'h004;
  localparam logic [12:0] A_BAUD = 13'h008;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr = 1'b0, rd = 1'b0;
  logic [12:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] bus_o;
  logic        tx_o, irq_o, rx_i;
  logic        rx_drv = 1'b1, loop_en = 1'b0;

  int n_pass = 0;
  int n_chk  = 0;

  logic       rec_en = 1'b0;
  logic       txq[$];
  logic [7:0] dec_b[$];
  int         dec_s[$];
  int         dec_bad;

  logic [7:0] m_data;
  logic       m_valid, m_ovr, m_ferr;

  always #5 clk = ~clk;

  assign rx_i = loop_en ? tx_o : rx_drv;

  riscv_io_uart dut (
    .clk_i (clk),
    .rst_i (rst),
    .addr_i(addr),
    .wr_i  (wr),
    .rd_i  (rd),
    .bus_i (wdata),
    .bus_o (bus_o),
    .rx_i  (rx_i),
    .tx_o  (tx_o),
    .irq_o (irq_o)
  );

  always @(negedge clk) if (rec_en) txq.push_back(tx_o);

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic bus_wr(input logic [12:0] a, input logic [31:0] d);
    @(negedge clk);
    addr = a; wdata = d; wr = 1'b1;
    @(negedge clk);
    wr = 1'b0;
  endtask

  task automatic bus_rd(input logic [12:0] a, output logic [31:0] d);
    @(negedge clk);
    addr = a; rd = 1'b1;
    @(negedge clk);
    d = bus_o; rd = 1'b0;
  endtask

  task automatic drive_rx(input logic [7:0] b, input logic stop, input int bl);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      rx_drv = f[k];
      repeat (bl - 1) @(negedge clk);
    end
    @(negedge clk);
    rx_drv = 1'b1;
  endtask

  // Serial receiver model over recorded tx_o samples
  task automatic decode_tx(input int bl);
    int i;
    logic [7:0] b;
    dec_b.delete(); dec_s.delete(); dec_bad = 0;
    i = 1;
    while (i + 10 * bl <= txq.size()) begin
      if (txq[i-1] === 1'b1 && txq[i] === 1'b0) begin
        for (int k = 0; k < 8; k++) b[k] = txq[i + bl/2 + (k+1)*bl];
        if (txq[i + bl/2 + 9*bl] !== 1'b1) dec_bad++;
        dec_b.push_back(b);
        dec_s.push_back(i);
        i = i + 10 * bl - 1;
      end else begin
        i++;
      end
    end
  endtask

  task automatic model_rx_good(input logic [7:0] b);
    if (m_valid) m_ovr = 1'b1;
    m_valid = 1'b1;
    m_data  = b;
  endtask

  function automatic logic [31:0] model_rx_flags();
    return {25'b0, 1'b0, m_ferr, 1'b0, m_ovr, m_valid, 2'b00};
  endfunction

  task automatic test_reset();
    logic [31:0] d;
    rst = 1'b1;
    m_data = '0; m_valid = 0; m_ovr = 0; m_ferr = 0;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({tx_o, irq_o, bus_o} !== {1'b1, 1'b0, 32'h0})
      $display("FAIL reset_pins: tx=%b irq=%b bus=%h, want 1 0 0", tx_o, irq_o, bus_o);
    else n_pass++;
    rst = 1'b0;
    bus_rd(A_BAUD, d);
    n_chk++;
    if (d !== 32'd867) $display("FAIL reset_baud: got %0d want 867", d);
    else n_pass++;
    @(negedge clk);
    n_chk++;
    if (bus_o !== 32'h0) $display("FAIL bus_idle_zero: got %h want 0", bus_o);
    else n_pass++;
    bus_rd(A_STAT, d);
    n_chk++;
    if (d !== 32'h2) $display("FAIL reset_status: got %h want 2", d);
    else n_pass++;
    bus_rd(A_DATA, d);
    n_chk++;
    if (d !== 32'h0) $display("FAIL reset_data: got %h want 0", d);
    else n_pass++;
    bus_rd(13'h1008, d);
    n_chk++;
    if (d !== 32'h0) $display("FAIL unmapped_read: got %h want 0", d);
    else n_pass++;
  endtask

  task automatic test_baud();
    logic [31:0] v, d;
    for (int t = 0; t < 3; t++) begin
      v = $urandom;
      bus_wr(A_BAUD, v);
      bus_rd(A_BAUD, d);
      n_chk++;
      if (d !== {16'h0, v[15:0]})
        $display("FAIL baud_rw: got %h want %h", d, {16'h0, v[15:0]});
      else n_pass++;
    end
    bus_wr(A_BAUD, 32'd3);
  endtask

  task automatic test_tx_frame();
    logic       ts [45];
    logic [31:0] ss [45];
    logic [7:0] b;
    logic [9:0] got, exp;
    for (int t = 0; t < 4; t++) begin
      b = (t == 0) ? 8'hA5 : 8'($urandom);
      @(negedge clk);
      addr = A_DATA; wdata = {24'h0, b}; wr = 1'b1;
      @(negedge clk);
      wr = 1'b0; addr = A_STAT; rd = 1'b1;
      ts[0] = tx_o; ss[0] = bus_o;
      for (int i = 1; i <= 44; i++) begin
        @(negedge clk);
        ts[i] = tx_o; ss[i] = bus_o;
      end
      rd = 1'b0;
      n_chk++;
      if ({ts[0], ts[1]} !== 2'b10)
        $display("FAIL tx_start_edge: tx c0/c1 %b%b want 10", ts[0], ts[1]);
      else n_pass++;
      exp = {1'b1, b, 1'b0};
      for (int k = 0; k < 10; k++) got[k] = ts[3 + 4*k];
      n_chk++;
      if (got !== exp) $display("FAIL tx_frame: got %b want %b", got, exp);
      else n_pass++;
      n_chk++;
      if ({ss[1][4], ss[2][4], ss[41][4], ss[42][4]} !== 4'b0110)
        $display("FAIL tx_busy_window: got %b want 0110",
                 {ss[1][4], ss[2][4], ss[41][4], ss[42][4]});
      else n_pass++;
      n_chk++;
      if ({ss[1][1], ss[2][1]} !== 2'b01)
        $display("FAIL tx_empty_edge: got %b want 01", {ss[1][1], ss[2][1]});
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  bytes [6];
    logic [31:0] d;
    logic [39:0] got, exp;
    int          gap_bad;
    for (int i = 0; i < 6; i++) bytes[i] = 8'($urandom);
    txq.delete();
    rec_en = 1'b1;
    for (int i = 0; i < 5; i++) bus_wr(A_DATA, {24'h0, bytes[i]});
    bus_rd(A_STAT, d);
    n_chk++;
    if (d !== 32'h11) $display("FAIL fifo_full_status: got %h want 11", d);
    else n_pass++;
    bus_wr(A_DATA, {24'h0, bytes[5]});
    bus_rd(A_STAT, d);
    n_chk++;
    if (d !== 32'h51) $display("FAIL fifo_drop_status: got %h want 51", d);
    else n_pass++;
    repeat (230) @(negedge clk);
    rec_en = 1'b0;
    decode_tx(4);
    n_chk++;
    if (dec_b.size() !== 5) $display("FAIL b2b_count: got %0d want 5", dec_b.size());
    else n_pass++;
    got = 'x;
    for (int i = 0; i < 5; i++) begin
      exp[8*i +: 8] = bytes[i];
      if (i < dec_b.size()) got[8*i +: 8] = dec_b[i];
    end
    n_chk++;
    if (got !== exp) $display("FAIL b2b_bytes: got %h want %h", got, exp);
    else n_pass++;
    gap_bad = 0;
    for (int i = 0; i + 1 < dec_s.size(); i++)
      if (dec_s[i+1] - dec_s[i] != 40) gap_bad++;
    n_chk++;
    if (gap_bad + dec_bad !== 0)
      $display("FAIL b2b_spacing: bad gaps %0d bad stops %0d want 0 0", gap_bad, dec_bad);
    else n_pass++;
    bus_wr(A_STAT, 32'h40);
    bus_rd(A_STAT, d);
    n_chk++;
    if (d !== 32'h2) $display("FAIL drop_clear: got %h want 2", d);
    else n_pass++;
  endtask

  task automatic test_loopback();
    logic [7:0]  b;
    logic [31:0] d;
    int          c;
    bus_wr(A_BAUD, 32'd7);
    loop_en = 1'b1;
    for (int t = 0; t < 3; t++) begin
      b = (t == 0) ? 8'h3C : 8'($urandom);
      bus_wr(A_DATA, {24'h0, b});
      c = 0;
      while (!irq_o && c < 200) begin
        @(negedge clk);
        c++;
      end
      model_rx_good(b);
      n_chk++;
      if (irq_o !== 1'b1) $display("FAIL loop_irq: got %b want 1 (timeout)", irq_o);
      else n_pass++;
      bus_rd(A_DATA, d);
      n_chk++;
      if (d !== {24'h0, m_data}) $display("FAIL loop_data: got %h want %h", d, m_data);
      else n_pass++;
      bus_rd(A_STAT, d);
      n_chk++;
      if ((d & 32'h6C) !== model_rx_flags())
        $display("FAIL loop_status: got %h want %h", d & 32'h6C, model_rx_flags());
      else n_pass++;
      bus_wr(A_STAT, 32'h4);
      m_valid = 1'b0;
      bus_rd(A_STAT, d);
      n_chk++;
      if ({irq_o, d & 32'h6C} !== {1'b0, model_rx_flags()})
        $display("FAIL loop_clear: irq %b flags %h want 0 %h", irq_o, d & 32'h6C,
                 model_rx_flags());
      else n_pass++;
      repeat (20) @(negedge clk);
    end
  endtask

  task automatic test_overrun();
    logic [7:0]  b1, b2;
    logic [31:0] d;
    b1 = 8'($urandom);
    b2 = 8'($urandom);
    bus_wr(A_DATA, {24'h0, b1});
    bus_wr(A_DATA, {24'h0, b2});
    repeat (220) @(negedge clk);
    model_rx_good(b1);
    model_rx_good(b2);
    bus_rd(A_STAT, d);
    n_chk++;
    if ((d & 32'h6C) !== model_rx_flags())
      $display("FAIL overrun_status: got %h want %h", d & 32'h6C, model_rx_flags());
    else n_pass++;
    bus_rd(A_DATA, d);
    n_chk++;
    if (d !== {24'h0, m_data}) $display("FAIL overrun_data: got %h want %h", d, m_data);
    else n_pass++;
    bus_wr(A_STAT, 32'h0C);
    m_valid = 1'b0; m_ovr = 1'b0;
    bus_rd(A_STAT, d);
    n_chk++;
    if ((d & 32'h6C) !== model_rx_flags())
      $display("FAIL overrun_clear: got %h want %h", d & 32'h6C, model_rx_flags());
    else n_pass++;
    loop_en = 1'b0;
  endtask

  task automatic test_rx_inject();
    logic [7:0]  b;
    logic [31:0] d;
    b = 8'($urandom);
    drive_rx(b, 1'b0, 8);
    repeat (4) @(negedge clk);
    m_ferr = 1'b1;
    bus_rd(A_STAT, d);
    n_chk++;
    if ((d & 32'h6C) !== model_rx_flags())
      $display("FAIL ferr_status: got %h want %h", d & 32'h6C, model_rx_flags());
    else n_pass++;
    bus_rd(A_DATA, d);
    n_chk++;
    if (d !== {24'h0, m_data}) $display("FAIL ferr_data_kept: got %h want %h", d, m_data);
    else n_pass++;
    bus_wr(A_STAT, 32'h20);
    m_ferr = 1'b0;
    b = 8'($urandom);
    drive_rx(b, 1'b1, 8);
    repeat (4) @(negedge clk);
    model_rx_good(b);
    bus_rd(A_STAT, d);
    n_chk++;
    if ((d & 32'h6C) !== model_rx_flags())
      $display("FAIL inject_status: got %h want %h", d & 32'h6C, model_rx_flags());
    else n_pass++;
    bus_rd(A_DATA, d);
    n_chk++;
    if (d !== {24'h0, m_data}) $display("FAIL inject_data: got %h want %h", d, m_data);
    else n_pass++;
    bus_wr(A_STAT, 32'h4);
    m_valid = 1'b0;
  endtask

  task automatic test_glitch();
    logic [31:0] d;
    @(negedge clk);
    rx_drv = 1'b0;
    @(negedge clk);
    rx_drv = 1'b1;
    repeat (40) @(negedge clk);
    bus_rd(A_STAT, d);
    n_chk++;
    if ((d & 32'h6C) !== model_rx_flags())
      $display("FAIL glitch_status: got %h want %h", d & 32'h6C, model_rx_flags());
    else n_pass++;
    bus_rd(A_DATA, d);
    n_chk++;
    if (d !== {24'h0, m_data}) $display("FAIL glitch_data: got %h want %h", d, m_data);
    else n_pass++;
  endtask

  task automatic test_reset_mid_tx();
    logic [31:0] d;
    int          zeros;
    bus_wr(A_DATA, 32'h0);
    repeat (12) @(negedge clk);
    n_chk++;
    if (tx_o !== 1'b0) $display("FAIL mid_frame_low: got %b want 0", tx_o);
    else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_chk++;
    if (tx_o !== 1'b1) $display("FAIL async_reset_tx: got %b want 1", tx_o);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    m_valid = 0; m_ovr = 0; m_ferr = 0; m_data = '0;
    bus_rd(A_STAT, d);
    n_chk++;
    if (d !== 32'h2) $display("FAIL post_reset_status: got %h want 2", d);
    else n_pass++;
    txq.delete();
    rec_en = 1'b1;
    repeat (120) @(negedge clk);
    rec_en = 1'b0;
    zeros = 0;
    foreach (txq[i]) if (txq[i] !== 1'b1) zeros++;
    n_chk++;
    if (zeros !== 0) $display("FAIL post_reset_line: %0d low samples, want 0", zeros);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_baud();
    test_tx_frame();
    test_back_to_back();
    test_loopback();
    test_overrun();
    test_rx_inject();
    test_glitch();
    test_reset_mid_tx();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
